// File: rtl/hex_text_pkg.sv
// Shared constants and types for the hex text buffer: grid geometry, bus widths,
// pixel pipeline depth and the clear/idle state encoding.
package hex_text_pkg;

    localparam int COLS    = 32;
    localparam int ROWS    = 16;
    localparam int ADDR_W  = 9;
    localparam int DIGIT_W = 4;
    localparam int PIX_LAT = 2;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    // Pixel-side sideband that travels alongside the RAM read.
    typedef struct packed {
        logic [2:0] xofs;
        logic [2:0] yofs;
        logic       display_on;
        logic       hsync;
        logic       vsync;
    } side_t;

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character store: one write port and one registered read port.
// A read and a write to the same address in one cycle return the old contents.
module text_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Both accesses sample the array before the write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hex_text_buffer.sv
// Hex digit character store feeding the font decoder: CPU write port, automatic
// clear sequencer, and a fixed two-cycle pixel fetch pipeline.
module hex_text_buffer #(
    parameter int         COLS      = hex_text_pkg::COLS,
    parameter int         ROWS      = hex_text_pkg::ROWS,
    parameter logic [3:0] CLEAR_VAL = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hpos,
    input  logic [6:0] vpos,
    input  logic       display_on,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [8:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       clr_req,
    output logic       busy,
    output logic [3:0] digit,
    output logic [2:0] xofs,
    output logic [2:0] yofs,
    output logic       display_on_o,
    output logic       hsync_o,
    output logic       vsync_o
);

    import hex_text_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   cnt_next;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [DIGIT_W-1:0]  ram_wdata;
    logic [ADDR_W-1:0]   ram_raddr;
    logic [DIGIT_W-1:0]  ram_rdata;
    side_t               side_in;
    side_t               side_pipe [PIX_LAT];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The clear sequencer owns the RAM write port; CPU writes only get through in IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ram_we     = 1'b0;
        ram_waddr  = wr_addr;
        ram_wdata  = wr_data;
        case (state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = cnt;
                ram_wdata = CLEAR_VAL;
                cnt_next  = cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ram_we = wr_valid;
                if (clr_req) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    assign wr_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_CLEAR);
    assign ram_raddr = {vpos[6:3], hpos[7:3]};

    text_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DIGIT_W)
    ) u_text_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign side_in = '{xofs:       hpos[2:0],
                       yofs:       vpos[2:0],
                       display_on: display_on,
                       hsync:      hsync,
                       vsync:      vsync};

    // Sideband delay matches RAM read (stage 1) plus output register (stage 2).
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < PIX_LAT; i++) begin
                side_pipe[i] <= '0;
            end
            digit <= '0;
        end else begin
            side_pipe[0] <= side_in;
            for (int i = 1; i < PIX_LAT; i++) begin
                side_pipe[i] <= side_pipe[i-1];
            end
            digit <= ram_rdata;
        end
    end

    assign xofs         = side_pipe[PIX_LAT-1].xofs;
    assign yofs         = side_pipe[PIX_LAT-1].yofs;
    assign display_on_o = side_pipe[PIX_LAT-1].display_on;
    assign hsync_o      = side_pipe[PIX_LAT-1].hsync;
    assign vsync_o      = side_pipe[PIX_LAT-1].vsync;

endmodule
